// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the digit-serial adder.
// Holds the controller state enum, default operand/digit widths and small
//   elaboration helpers used to size the digit counter.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DIGIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of digit steps needed to cover a full operand.
    function automatic int digit_count(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter width for n steps; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// digit_adder: DIGIT-bit ripple-carry adder built from per-bit generate/propagate.
// Ports: i_a/i_b digit operands, i_cin carry in; o_sum digit sum, o_cout carry
//   out of the top bit, o_c_msb carry into the top bit (for overflow detection).
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_msb
);

    logic [DIGIT-1:0] w_g;
    logic [DIGIT-1:0] w_p;
    logic [DIGIT:0]   w_c;

    assign w_g    = i_a & i_b;
    assign w_p    = i_a ^ i_b;
    assign w_c[0] = i_cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end

    assign o_sum   = w_p ^ w_c[DIGIT-1:0];
    assign o_cout  = w_c[DIGIT];
    assign o_c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: adds two WIDTH-bit operands DIGIT bits per clock (LSB digit first).
// Ports: clk/rst (async active-high); in_valid/in_ready + a, b, cin operand
//   handshake; out_valid/out_ready + sum, cout, ovf result handshake.
// Latency: out_valid rises WIDTH/DIGIT cycles after the accepting edge; one
//   operation in flight, no new operands until the result is taken.
// Optional: define SERIAL_ADDER_SUB_EN to add input 'sub' (a + ~b + (cin^1)).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
        $error("serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
    end

    localparam int N  = digit_count(WIDTH, DIGIT);
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;
    logic   w_load;
    logic   w_step;
    logic   w_last;
    logic   w_in_ready;
    logic   w_out_valid;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_step = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic w_sub;
`ifdef SERIAL_ADDER_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    // Operands shift right one digit per step so the adder always sees the
    // low digit; the partial sum fills from the top and lands aligned after
    // N steps.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [DIGIT-1:0] w_dsum;
    logic             w_dcout;
    logic             w_dc_msb;
    logic [WIDTH-1:0] w_acc_nxt;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .i_a     (r_a[DIGIT-1:0]),
        .i_b     (r_b[DIGIT-1:0]),
        .i_cin   (r_carry),
        .o_sum   (w_dsum),
        .o_cout  (w_dcout),
        .o_c_msb (w_dc_msb)
    );

    always_comb begin
        w_acc_nxt = r_acc >> DIGIT;
        w_acc_nxt[WIDTH-1 -: DIGIT] = w_dsum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_load) begin
            // Subtraction folds into the add: invert B once at capture and
            // flip the incoming carry.
            r_a     <= a;
            r_b     <= b ^ {WIDTH{w_sub}};
            r_carry <= cin ^ w_sub;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_acc   <= w_acc_nxt;
            r_carry <= w_dcout;
            r_cnt   <= r_cnt + CW'(1);
            // Visible results only change on the final digit so they hold
            // their previous values while a new operation is in progress.
            if (w_last) begin
                r_sum  <= w_acc_nxt;
                r_cout <= w_dcout;
                r_ovf  <= w_dc_msb ^ w_dcout;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef SERIAL_ADDER_SUB_EN
    localparam bit HAS_SUB = 1'b1;
    logic tsub;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic [7:0] ta;
    logic [7:0] tb_v;
    logic       tcin;
    logic       tout_ready;

    logic       iv0, ir0, ov0, c0, o0;
    logic [7:0] s0;
    logic       iv1, ir1, ov1, c1, o1;
    logic [7:0] s1;

    int n_checks = 0;
    int n_pass   = 0;

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv0),
        .in_ready  (ir0),
        .a         (ta),
        .b         (tb_v),
        .cin       (tcin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (tsub),
`endif
        .out_valid (ov0),
        .out_ready (tout_ready),
        .sum       (s0),
        .cout      (c0),
        .ovf       (o0)
    );

    serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv1),
        .in_ready  (ir1),
        .a         (ta),
        .b         (tb_v),
        .cin       (tcin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (tsub),
`endif
        .out_valid (ov1),
        .out_ready (tout_ready),
        .sum       (s1),
        .cout      (c1),
        .ovf       (o1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       c;
        logic       o;
    } vec_t;

    vec_t vecs[$];
    vec_t vecs8[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic on the operands as the user sees them.
    function automatic logic [9:0] model(input logic [7:0] xa, input logic [7:0] xb,
                                         input logic xc, input logic xs);
        logic [7:0] bb;
        int         cc;
        int         u;
        int         sv;
        logic [7:0] rs;
        logic       rc;
        logic       ro;
        bb = xs ? ~xb : xb;
        cc = (xc ^ xs) ? 1 : 0;
        u  = int'(xa) + int'(bb) + cc;
        sv = int'($signed(xa)) + int'($signed(bb)) + cc;
        rs = u[7:0];
        rc = (u > 255);
        ro = (sv > 127) || (sv < -128);
        return {ro, rc, rs};
    endfunction

    task automatic run_op(input int sel, input logic [7:0] xa, input logic [7:0] xb,
                          input logic xc, input logic xs, input int hold,
                          output logic [7:0] rs, output logic rc, output logic ro,
                          output int lat);
        int guard;
        guard = 0;
        while (!(sel == 0 ? ir0 : ir1) && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        ta = xa; tb_v = xb; tcin = xc; tout_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        tsub = xs;
`endif
        if (sel == 0) iv0 = 1'b1; else iv1 = 1'b1;
        @(posedge clk); #1;
        iv0 = 1'b0; iv1 = 1'b0;
        lat = 0;
        while (!(sel == 0 ? ov0 : ov1) && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        rs = (sel == 0) ? s0 : s1;
        rc = (sel == 0) ? c0 : c1;
        ro = (sel == 0) ? o0 : o1;
        repeat (hold) begin @(posedge clk); #1; end
        tout_ready = 1'b1;
        @(posedge clk); #1;
        tout_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rs;
        logic       rc, ro;
        int         lat;
        logic [9:0] m;
        logic [7:0] ra, rb;
        logic       rcin, rsub;
        int         hold, guard;

        vecs.push_back('{a:8'hFF, b:8'h01, cin:1'b0, sub:1'b0, s:8'h00, c:1'b1, o:1'b0});
        vecs.push_back('{a:8'h7F, b:8'h01, cin:1'b0, sub:1'b0, s:8'h80, c:1'b0, o:1'b1});
        vecs.push_back('{a:8'h80, b:8'h80, cin:1'b0, sub:1'b0, s:8'h00, c:1'b1, o:1'b1});
        vecs.push_back('{a:8'h12, b:8'h34, cin:1'b0, sub:1'b0, s:8'h46, c:1'b0, o:1'b0});
        vecs.push_back('{a:8'h0F, b:8'h01, cin:1'b0, sub:1'b0, s:8'h10, c:1'b0, o:1'b0});
        vecs.push_back('{a:8'hFF, b:8'hFF, cin:1'b1, sub:1'b0, s:8'hFF, c:1'b1, o:1'b0});
        vecs.push_back('{a:8'h00, b:8'h00, cin:1'b1, sub:1'b0, s:8'h01, c:1'b0, o:1'b0});
        vecs.push_back('{a:8'h7F, b:8'h7F, cin:1'b1, sub:1'b0, s:8'hFF, c:1'b0, o:1'b1});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{a:8'h05, b:8'h07, cin:1'b0, sub:1'b1, s:8'hFE, c:1'b0, o:1'b0});
        vecs.push_back('{a:8'h07, b:8'h05, cin:1'b0, sub:1'b1, s:8'h02, c:1'b1, o:1'b0});
        vecs.push_back('{a:8'h80, b:8'h01, cin:1'b0, sub:1'b1, s:8'h7F, c:1'b1, o:1'b1});
`endif
        vecs8.push_back('{a:8'h10, b:8'h20, cin:1'b0, sub:1'b0, s:8'h30, c:1'b0, o:1'b0});
        vecs8.push_back('{a:8'hFF, b:8'h01, cin:1'b0, sub:1'b0, s:8'h00, c:1'b1, o:1'b0});
        vecs8.push_back('{a:8'h40, b:8'h40, cin:1'b0, sub:1'b0, s:8'h80, c:1'b0, o:1'b1});

        // Reset state
        rst = 1'b1; iv0 = 1'b0; iv1 = 1'b0; tout_ready = 1'b0;
        ta = '0; tb_v = '0; tcin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        tsub = 1'b0;
`endif
        #1;
        chk("rst_in_ready", ir0, 1);
        chk("rst_out_valid", ov0, 0);
        chk("rst_sum", s0, 0);
        chk("rst_cout", c0, 0);
        chk("rst_ovf", o0, 0);
        chk("rst_in_ready_d8", ir1, 1);
        chk("rst_out_valid_d8", ov1, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", ir0, 1);
        chk("idle_out_valid", ov0, 0);

        // Directed table, DIGIT=4
        foreach (vecs[i]) begin
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 0, rs, rc, ro, lat);
            chk($sformatf("vec%0d_sum", i), rs, vecs[i].s);
            chk($sformatf("vec%0d_cout", i), rc, vecs[i].c);
            chk($sformatf("vec%0d_ovf", i), ro, vecs[i].o);
            chk($sformatf("vec%0d_latency", i), lat, 2);
        end

        // Directed table, DIGIT=8
        foreach (vecs8[i]) begin
            run_op(1, vecs8[i].a, vecs8[i].b, vecs8[i].cin, vecs8[i].sub, 0, rs, rc, ro, lat);
            chk($sformatf("d8vec%0d_sum", i), rs, vecs8[i].s);
            chk($sformatf("d8vec%0d_cout", i), rc, vecs8[i].c);
            chk($sformatf("d8vec%0d_ovf", i), ro, vecs8[i].o);
            chk($sformatf("d8vec%0d_latency", i), lat, 1);
        end

        // Result held in DONE under backpressure with in_valid kept high
        ta = 8'h3C; tb_v = 8'h4B; tcin = 1'b0; tout_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        tsub = 1'b0;
`endif
        iv0 = 1'b1;
        @(posedge clk); #1;
        ta = 8'hAA; tb_v = 8'h55; tcin = 1'b1;
        guard = 0;
        while (!ov0 && guard < 20) begin @(posedge clk); #1; guard++; end
        chk("bp_latency", guard, 2);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_sum", k), s0, 8'h87);
            chk($sformatf("bp%0d_cout", k), c0, 0);
            chk($sformatf("bp%0d_ovf", k), o0, 1);
            chk($sformatf("bp%0d_in_ready", k), ir0, 0);
            chk($sformatf("bp%0d_out_valid", k), ov0, 1);
            @(posedge clk); #1;
        end
        tout_ready = 1'b1;
        @(posedge clk); #1;
        tout_ready = 1'b0; iv0 = 1'b0;
        chk("bp_after_out_valid", ov0, 0);
        chk("bp_after_in_ready", ir0, 1);
        chk("bp_after_sum_hold", s0, 8'h87);

        // Reset during the second BUSY cycle
        ta = 8'h11; tb_v = 8'h22; tcin = 1'b0;
        iv0 = 1'b1;
        @(posedge clk); #1;
        iv0 = 1'b0;
        chk("busy_in_ready", ir0, 0);
        chk("busy_sum_hold", s0, 8'h87);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", ir0, 1);
        chk("midrst_sum", s0, 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst_in_ready", ir0, 1);
        chk("postrst_out_valid", ov0, 0);
        chk("postrst_sum", s0, 0);
        chk("postrst_cout", c0, 0);
        chk("postrst_ovf", o0, 0);
        run_op(0, 8'h12, 8'h34, 1'b0, 1'b0, 0, rs, rc, ro, lat);
        chk("postrst_add_sum", rs, 8'h46);
        chk("postrst_add_latency", lat, 2);

        // Randomized against the reference model
        for (int i = 0; i < 120; i++) begin
            int sel;
            sel  = (i % 4 == 3) ? 1 : 0;
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rcin = 1'($urandom);
            rsub = HAS_SUB ? 1'($urandom) : 1'b0;
            hold = $urandom_range(0, 2);
            m = model(ra, rb, rcin, rsub);
            run_op(sel, ra, rb, rcin, rsub, hold, rs, rc, ro, lat);
            chk($sformatf("rnd%0d_sum", i), rs, m[7:0]);
            chk($sformatf("rnd%0d_cout", i), rc, m[8]);
            chk($sformatf("rnd%0d_ovf", i), ro, m[9]);
            chk($sformatf("rnd%0d_latency", i), lat, (sel == 1) ? 1 : 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
